// File: rtl/tele_stop_if.sv
// Signal bundle between the pulse generators/sensors and the stop interlock.
// master drives detect inputs and raw pulses; slave returns gated pulses and status.
interface tele_stop_if;
  logic [3:0] petectIO;
  logic [5:0] thrusterPluseA;
  logic [5:0] thrusterPluseB;
  logic [5:0] safetyPluseA;
  logic [5:0] safetyPluseB;
  logic       redLed;
  logic       greenLed;
  logic       BZ;

  modport master (
    output petectIO, thrusterPluseA, thrusterPluseB,
    input  safetyPluseA, safetyPluseB, redLed, greenLed, BZ
  );

  modport slave (
    input  petectIO, thrusterPluseA, thrusterPluseB,
    output safetyPluseA, safetyPluseB, redLed, greenLed, BZ
  );
endinterface

// File: rtl/tele_stop.sv
// Stepper safety interlock: debounced detect inputs latch a sticky stop that
// forces both pulse groups low and drives status LEDs and a beeping buzzer.
module tele_stop #(
  parameter int unsigned DEBOUNCE_CYC  = 100000,
  parameter int unsigned BZ_HALF_CYC   = 25000,
  parameter int unsigned BEEP_HALF_CYC = 25000000,
  parameter bit          FAULT_POL     = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  tele_stop_if.slave bus
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned ToneW = $clog2(BZ_HALF_CYC + 1);
  localparam int unsigned BeepW = $clog2(BEEP_HALF_CYC + 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [DbW-1:0]   db_cnt_q [4];
  logic [DbW-1:0]   db_cnt_d [4];
  logic             stop_q, stop_d;
  logic             trip;
  logic [ToneW-1:0] tone_cnt_q;
  logic [BeepW-1:0] beep_cnt_q;
  logic             tone_q, gate_q;

  // Per-bit saturating run counters; a bit trips the cycle its run reaches the limit.
  always_comb begin
    trip     = 1'b0;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == FAULT_POL) begin
        if (db_cnt_q[i] != DbW'(DEBOUNCE_CYC)) begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
        if (db_cnt_d[i] == DbW'(DEBOUNCE_CYC)) begin
          trip = 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
    stop_d = stop_q | trip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      db_cnt_q         <= '{default: '0};
      stop_q           <= 1'b0;
      tone_cnt_q       <= '0;
      beep_cnt_q       <= '0;
      tone_q           <= 1'b0;
      gate_q           <= 1'b0;
      bus.safetyPluseA <= '0;
      bus.safetyPluseB <= '0;
      bus.redLed       <= 1'b0;
      bus.greenLed     <= 1'b0;
      bus.BZ           <= 1'b0;
    end else begin
      sync1_q  <= bus.petectIO;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      stop_q   <= stop_d;

      // Preloading tone/gate to 1 while running makes both start high on the stop edge.
      if (!stop_q) begin
        tone_cnt_q <= '0;
        beep_cnt_q <= '0;
        tone_q     <= 1'b1;
        gate_q     <= 1'b1;
      end else begin
        if (tone_cnt_q == ToneW'(BZ_HALF_CYC - 1)) begin
          tone_cnt_q <= '0;
          tone_q     <= ~tone_q;
        end else begin
          tone_cnt_q <= tone_cnt_q + ToneW'(1);
        end
        if (beep_cnt_q == BeepW'(BEEP_HALF_CYC - 1)) begin
          beep_cnt_q <= '0;
          gate_q     <= ~gate_q;
        end else begin
          beep_cnt_q <= beep_cnt_q + BeepW'(1);
        end
      end

      bus.safetyPluseA <= stop_q ? 6'b0 : bus.thrusterPluseA;
      bus.safetyPluseB <= stop_q ? 6'b0 : bus.thrusterPluseB;
      bus.redLed       <= stop_q;
      bus.greenLed     <= ~stop_q;
      bus.BZ           <= stop_q & tone_q & gate_q;
    end
  end

endmodule

// File: tb/tb_tele_stop.sv
// Randomized bench for tele_stop against an edge-counting reference model.
module tb_tele_stop;
  localparam int unsigned Deb  = 4;
  localparam int unsigned Tone = 2;
  localparam int unsigned Beep = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tele_stop_if bus ();

  tele_stop #(
    .DEBOUNCE_CYC (Deb),
    .BZ_HALF_CYC  (Tone),
    .BEEP_HALF_CYC(Beep),
    .FAULT_POL    (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sync history, fault run lengths, stop edge index.
  logic [3:0] m_s1, m_s2;
  int         m_run [4];
  bit         m_stop;
  int         m_edge, m_stop_edge;
  logic [5:0] e_a, e_b;
  logic       e_red, e_green, e_bz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_stop      = 1'b0;
    m_edge      = 0;
    m_stop_edge = 0;
    e_a = '0; e_b = '0; e_red = 1'b0; e_green = 1'b0; e_bz = 1'b0;
  endtask

  task automatic model_edge();
    int j;
    e_a     = m_stop ? 6'h0 : bus.thrusterPluseA;
    e_b     = m_stop ? 6'h0 : bus.thrusterPluseB;
    e_red   = m_stop;
    e_green = !m_stop;
    j       = m_edge - 1 - m_stop_edge;
    e_bz    = m_stop && ((j / Tone) % 2 == 0) && ((j / Beep) % 2 == 0);
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i]) m_run[i] = (m_run[i] < Deb) ? m_run[i] + 1 : Deb;
      else m_run[i] = 0;
      if (m_run[i] >= Deb && !m_stop) begin
        m_stop      = 1'b1;
        m_stop_edge = m_edge;
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.petectIO;
    m_edge++;
  endtask

  task automatic check_outputs();
    check("safetyA", 32'(bus.safetyPluseA), 32'(e_a));
    check("safetyB", 32'(bus.safetyPluseB), 32'(e_b));
    check("redLed", 32'(bus.redLed), 32'(e_red));
    check("greenLed", 32'(bus.greenLed), 32'(e_green));
    check("BZ", 32'(bus.BZ), 32'(e_bz));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic [3:0] p);
    bus.petectIO       = p;
    bus.thrusterPluseA = 6'($urandom);
    bus.thrusterPluseB = 6'($urandom);
    step();
  endtask

  task automatic trip_latency(input string tag, input logic [3:0] p);
    int lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      drive(p);
      if (bus.redLed) lat = k;
    end
    check(tag, 32'(lat), 32'd7);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'(bus.safetyPluseA), 32'd0);
    check({tag, "_b"}, 32'(bus.safetyPluseB), 32'd0);
    check({tag, "_red"}, 32'(bus.redLed), 32'd0);
    check({tag, "_green"}, 32'(bus.greenLed), 32'd0);
    check({tag, "_bz"}, 32'(bus.BZ), 32'd0);
  endtask

  initial begin
    bus.petectIO       = '0;
    bus.thrusterPluseA = '0;
    bus.thrusterPluseB = '0;
    model_reset();
    repeat (3) step();
    check_all_zero("reset");

    // Release with a known pattern on group A.
    rst_n              = 1'b1;
    bus.petectIO       = '0;
    bus.thrusterPluseA = 6'h2A;
    bus.thrusterPluseB = 6'h15;
    step();
    check("pass_2A", 32'(bus.safetyPluseA), 32'h2A);
    check("pass_green", 32'(bus.greenLed), 32'd1);
    repeat (20) drive(4'h0);

    // Short glitches on bit 0 must never trip.
    repeat (6) begin
      repeat (3) drive(4'h1);
      repeat (2) drive(4'h0);
    end
    check("glitch_no_trip", 32'(bus.redLed), 32'd0);

    // Stable fault on bit 2; stop is sticky after removal, buzzer runs.
    trip_latency("trip_lat_bit2", 4'h4);
    repeat (3) drive(4'h4);
    repeat (60) drive(4'h0);
    check("sticky_red", 32'(bus.redLed), 32'd1);

    // Asynchronous reset mid-stop.
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) drive(4'h0);
    check("rerun_green", 32'(bus.greenLed), 32'd1);

    // Two bits together: a single trip gating both groups.
    trip_latency("trip_lat_bits13", 4'hA);
    repeat (20) drive(4'hA);

    // Randomized rounds of mixed glitches and sustained faults.
    for (int r = 0; r < 6; r++) begin
      rst_n = 1'b0;
      #1;
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      for (int s = 0; s < 60; s++) begin
        if ($urandom_range(0, 9) == 0) begin
          logic [3:0] p;
          int len;
          p   = 4'($urandom_range(1, 15));
          len = $urandom_range(1, 6);
          repeat (len) drive(p);
        end else begin
          drive(4'h0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
